ltc2333_read: RTL and testbench
===============================

# ltc2333_read

Serial-data receiver for the LTC2333 ADC pair. It captures the two SDO lanes bit-by-bit on sample strobes supplied by the conversion/clock generator that drives CNV/SCKI/SDI. It assembles 24-bit result packets and checks each packet's channel ID and SoftSpan against the active configuration. Results are presented on a buffered valid/ready stream to the DAQ readout path. It sits beside the ADC write/control block in the fabric clock domain and shares its active-channel mask and range settings.

## Interface

Parameters:
- N_LANES, 2, number of ADCs read in parallel (one SDO per ADC)
- WORD_BITS, 24, bits per LTC2333 output packet
- FIFO_DEPTH, 4, output buffer depth in frames-words (power of two)

Ports:
- clk  input  1  fabric clock; all logic on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- sample_strobe  input  1  one-cycle pulse per SCKI bit; SDO is valid in this cycle
- frame_start  input  1  one-cycle pulse at the start of a readout (after conversion ends)
- active_channels  input  8  channel enable mask, bit n = channel n
- range  input  3  expected SoftSpan code
- sdo  input  N_LANES  serial data from each ADC, MSB first
- m_data  output  N_LANES*WORD_BITS  packed packets, lane 0 in the low 24 bits
- m_chan  output  3  expected channel ID of this word
- m_last  output  1  word is the final one of its frame
- m_valid  output  1  stream valid
- m_ready  input  1  stream ready
- busy  output  1  frame capture in progress
- overflow  output  1  sticky: a word was dropped because the FIFO was full
- id_error  output  1  sticky: channel ID or SoftSpan mismatch on any lane
- frame_error  output  1  sticky: frame_start arrived mid-frame
- clear_flags  input  1  one-cycle pulse clearing all sticky flags

## Operation

- Packet format per lane: [23:6] 18-bit result, [5:3] channel ID, [2:0] SoftSpan.
- States: IDLE, SHIFT.
- IDLE: on frame_start with active_channels != 0, snapshot the mask and range, set bit_cnt=0, set expected channel = lowest set mask bit, then go to SHIFT. If frame_start arrives with mask == 0, it is ignored.
- SHIFT: on each sample_strobe, shift each lane left by one with sdo[i] entering the LSB, and increment bit_cnt.
  - On the 24th strobe (bit_cnt wraps 23->0), the word is complete.
  - Compare each lane's [5:3] to the expected channel and [2:0] to the snapshot range. Any mismatch sets id_error. The word is still delivered.
  - Push {lane words, expected channel, last}. last=1 when no higher set bit remains in the snapshot mask.
  - Advance the expected channel to the next higher set bit. On last, return to IDLE.
- sample_strobe in IDLE is ignored.
- frame_start in SHIFT discards the partial word, sets frame_error, and restarts as from IDLE using the current mask. If the current mask is 0, it goes to IDLE.
- FIFO full at push: the word is dropped, overflow is set, and the frame continues with expected-channel tracking unaffected.
- FIFO pop occurs when m_valid && m_ready. A simultaneous push and pop when full is legal: no drop.
- clear_flags has lower priority than a same-cycle set; the set wins.
- busy = (state == SHIFT).

## Timing

- Reset values: m_valid=0, m_data=0, m_chan=0, m_last=0, busy=0, overflow=0, id_error=0, frame_error=0. The FIFO is empty and the state is IDLE.
- busy rises the cycle after frame_start. It falls the cycle after the final 24th strobe's completion edge.
- Latency: with an empty FIFO, m_valid asserts 2 cycles after the cycle containing the 24th strobe. The word registers at strobe edge+1 and the FIFO output at +2.
- id_error asserts in the same cycle the word is pushed.
- m_data, m_chan and m_last are stable while m_valid && !m_ready. m_valid never drops without a handshake except on reset.
- Back-to-back strobes (every cycle) are supported. The minimum frame_start-to-first-strobe spacing is 1 cycle.
- Reset mid-frame: the partial word and FIFO contents are lost, and outputs return to reset values asynchronously.

## Test plan

- Mask 0x05, range 3'b111, lane0 sends 0x3FFFC7 then 0x000157, m_ready=1 → two words with m_chan 0 then 2, m_last 0 then 1, id_error=0, busy low after second word.
- Mask 0x01, lane1 packet carries channel ID 3 → word delivered, id_error=1. After clear_flags, id_error=0.
- Mask 0xFF, m_ready=0 for the whole frame → first 4 words held in order, overflow=1 at the 5th push. Releasing m_ready yields channels 0..3 and then m_valid=0.
- frame_start after 10 strobes of a frame → frame_error=1, no partial word output, and the next 24 strobes produce a correct channel-0 word.
- Mask 0x00, frame_start plus 24 strobes → busy stays 0 and no output.
- Assert reset asynchronously mid-shift with 2 words buffered → m_valid=0 immediately, all flags 0, and a subsequent frame captures correctly.

Source files
------------

// File: rtl/ltc2333_read.sv
// ltc2333_read: serial receiver for a pair (N_LANES) of LTC2333 ADCs.
// Captures one SDO bit per lane on each sample_strobe, assembles 24-bit
// packets, checks channel ID and SoftSpan against a per-frame snapshot of the
// active configuration, and buffers completed words in a small FIFO feeding a
// valid/ready stream.
//
// Ports:
//   clk, reset            fabric clock, async active-high reset
//   sample_strobe         one pulse per SCKI bit, sdo valid in that cycle
//   frame_start           start of a readout (after conversion)
//   active_channels[7:0]  channel enable mask
//   range[2:0]            expected SoftSpan code
//   sdo[N_LANES-1:0]      serial data, MSB first
//   m_data/m_chan/m_last/m_valid/m_ready  output stream (lane 0 in low bits)
//   busy                  frame capture in progress
//   overflow/id_error/frame_error  sticky flags, cleared by clear_flags

// Per-lane shift register and packet field checker.
module ltc2333_lane #(
  parameter int WORD_BITS = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 shift_en,
  input  logic                 sdo,
  input  logic [2:0]           chk_chan,
  input  logic [2:0]           chk_range,
  output logic [WORD_BITS-1:0] word,
  output logic                 mismatch
);
  always_ff @(posedge clk or posedge reset)
    if (reset)         word <= '0;
    else if (shift_en) word <= {word[WORD_BITS-2:0], sdo};

  assign mismatch = (word[5:3] != chk_chan) || (word[2:0] != chk_range);
endmodule

module ltc2333_read #(
  parameter int N_LANES    = 2,
  parameter int WORD_BITS  = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         sample_strobe,
  input  logic                         frame_start,
  input  logic [7:0]                   active_channels,
  input  logic [2:0]                   range,
  input  logic [N_LANES-1:0]           sdo,
  output logic [N_LANES*WORD_BITS-1:0] m_data,
  output logic [2:0]                   m_chan,
  output logic                         m_last,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic                         busy,
  output logic                         overflow,
  output logic                         id_error,
  output logic                         frame_error,
  input  logic                         clear_flags
);
  localparam int CW = $clog2(WORD_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WORD_BITS - 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  typedef struct packed {
    logic [N_LANES-1:0][WORD_BITS-1:0] data;
    logic [2:0]                        chan;
    logic                              last;
  } entry_t;

  // Lowest set bit of m at index >= from; 8 means none.
  function automatic logic [3:0] find_from(input logic [7:0] m, input logic [3:0] from);
    find_from = 4'd8;
    for (int i = 7; i >= 0; i--)
      if (m[i] && i >= int'(from)) find_from = i[3:0];
  endfunction

  state_t        state, state_n;
  logic [CW-1:0] bit_cnt, bit_cnt_n;
  logic [7:0]    mask_q, mask_n;
  logic [2:0]    range_q, range_n;
  logic [2:0]    exp_chan, chan_n;
  logic          done, done_last, fe_set, shift_en;
  logic [3:0]    first_ch, next_ch;

  // Completed-word stage: the lane shift registers hold the word for the
  // cycle after completion, since the next strobe is at least one cycle away.
  logic          word_vld, word_last;
  logic [2:0]    word_chan, word_range;

  logic [N_LANES-1:0][WORD_BITS-1:0] lane_word;
  logic [N_LANES-1:0]                lane_mis;

  assign first_ch = find_from(active_channels, 4'd0);
  assign next_ch  = find_from(mask_q, {1'b0, exp_chan} + 4'd1);
  assign shift_en = (state == SHIFT) && sample_strobe && !frame_start;
  assign busy     = (state == SHIFT);

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      mask_q   <= '0;
      range_q  <= '0;
      exp_chan <= '0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      mask_q   <= mask_n;
      range_q  <= range_n;
      exp_chan <= chan_n;
    end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    mask_n    = mask_q;
    range_n   = range_q;
    chan_n    = exp_chan;
    done      = 1'b0;
    done_last = 1'b0;
    fe_set    = 1'b0;
    if (frame_start) begin
      // A restart mid-frame drops the partial word.
      fe_set = (state == SHIFT);
      if (active_channels != 8'd0) begin
        state_n   = SHIFT;
        bit_cnt_n = '0;
        mask_n    = active_channels;
        range_n   = range;
        chan_n    = first_ch[2:0];
      end else begin
        state_n = IDLE;
      end
    end else if (state == SHIFT && sample_strobe) begin
      if (bit_cnt == LAST_BIT) begin
        bit_cnt_n = '0;
        done      = 1'b1;
        done_last = next_ch[3];
        if (next_ch[3]) state_n = IDLE;
        else            chan_n  = next_ch[2:0];
      end else begin
        bit_cnt_n = bit_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      word_vld   <= 1'b0;
      word_last  <= 1'b0;
      word_chan  <= '0;
      word_range <= '0;
    end else begin
      word_vld   <= done;
      word_last  <= done_last;
      word_chan  <= exp_chan;
      word_range <= range_q;
    end

  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    ltc2333_lane #(.WORD_BITS(WORD_BITS)) u_lane (
      .clk      (clk),
      .reset    (reset),
      .shift_en (shift_en),
      .sdo      (sdo[g]),
      .chk_chan (word_chan),
      .chk_range(word_range),
      .word     (lane_word[g]),
      .mismatch (lane_mis[g])
    );
  end

  // Output FIFO
  entry_t        mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, pop, wr_ok, drop;

  assign full    = (count == FULL_CNT);
  assign m_valid = (count != '0);
  assign pop     = m_valid && m_ready;
  // A pop in the same cycle frees the slot being written.
  assign wr_ok   = word_vld && (!full || pop);
  assign drop    = word_vld && full && !pop;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_ok) begin
        mem[wr_ptr] <= '{data: lane_word, chan: word_chan, last: word_last};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (wr_ok && !pop)      count <= count + 1'b1;
      else if (!wr_ok && pop) count <= count - 1'b1;
    end

  assign m_data = mem[rd_ptr].data;
  assign m_chan = mem[rd_ptr].chan;
  assign m_last = mem[rd_ptr].last;

  // Sticky flags: a same-cycle set beats clear_flags.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      overflow    <= 1'b0;
      id_error    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      overflow    <= drop                  || (overflow    && !clear_flags);
      id_error    <= (word_vld && |lane_mis) || (id_error  && !clear_flags);
      frame_error <= fe_set                || (frame_error && !clear_flags);
    end
endmodule

// File: tb/tb_ltc2333_read.sv
module tb_ltc2333_read;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_strobe = 1'b0, frame_start = 1'b0, m_ready = 1'b0, clear_flags = 1'b0;
  logic [7:0]  active_channels = 8'd0;
  logic [2:0]  range = 3'd0;
  logic [1:0]  sdo = 2'd0;
  logic [47:0] m_data;
  logic [2:0]  m_chan;
  logic        m_last, m_valid, busy, overflow, id_error, frame_error;

  int checks = 0;
  int errors = 0;

  ltc2333_read dut (
    .clk(clk), .reset(reset), .sample_strobe(sample_strobe), .frame_start(frame_start),
    .active_channels(active_channels), .range(range), .sdo(sdo),
    .m_data(m_data), .m_chan(m_chan), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .overflow(overflow), .id_error(id_error), .frame_error(frame_error),
    .clear_flags(clear_flags)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] pkt(input logic [17:0] res, input logic [2:0] ch, input logic [2:0] rg);
    return {res, ch, rg};
  endfunction

  task automatic fs(input logic [7:0] mask, input logic [2:0] rg);
    active_channels = mask;
    range = rg;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  // Sends the top n bits of each lane word, one strobe per cycle.
  task automatic send(input logic [23:0] a, input logic [23:0] b, input int n);
    for (int i = 23; i > 23 - n; i--) begin
      sdo = {b[i], a[i]};
      sample_strobe = 1'b1;
      step();
    end
    sample_strobe = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
  endtask

  initial begin
    step(); step();
    reset = 1'b0;
    step();
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {overflow, id_error, frame_error}, 0);

    // Two-word frame, channels 0 and 2
    m_ready = 1'b1;
    fs(8'h05, 3'b111);
    chk("t1_busy_rise", busy, 1);
    send(24'h3FFFC7, 24'h000007, 24);
    chk("t1_busy_mid", busy, 1);
    chk("t1_valid_early", m_valid, 0);
    step();
    chk("t1_w0_valid", m_valid, 1);
    chk("t1_w0_data", m_data, {24'h000007, 24'h3FFFC7});
    chk("t1_w0_chan", m_chan, 0);
    chk("t1_w0_last", m_last, 0);
    send(24'h000157, 24'h000017, 24);
    chk("t1_busy_fall", busy, 0);
    step();
    chk("t1_w1_valid", m_valid, 1);
    chk("t1_w1_data", m_data, {24'h000017, 24'h000157});
    chk("t1_w1_chan", m_chan, 2);
    chk("t1_w1_last", m_last, 1);
    chk("t1_id_error", id_error, 0);
    step();
    chk("t1_drained", m_valid, 0);

    // Lane 1 reports channel 3 while channel 0 is expected
    fs(8'h01, 3'b111);
    send(24'h000007, 24'h00001F, 24);
    step();
    chk("t2_valid", m_valid, 1);
    chk("t2_data", m_data, {24'h00001F, 24'h000007});
    chk("t2_last", m_last, 1);
    chk("t2_id_error", id_error, 1);
    step();
    pulse_clear();
    chk("t2_cleared", id_error, 0);

    // Full mask with m_ready held low: 4 words kept, 5th dropped
    m_ready = 1'b0;
    fs(8'hFF, 3'b111);
    for (int c = 0; c < 8; c++) begin
      send(pkt(18'(c + 1), 3'(c), 3'b111), pkt(18'(c + 100), 3'(c), 3'b111), 24);
      if (c == 4) chk("t3_no_ovf_yet", overflow, 0);
    end
    step();
    chk("t3_overflow", overflow, 1);
    chk("t3_busy", busy, 0);
    chk("t3_id_error", id_error, 0);
    m_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      chk("t3_valid", m_valid, 1);
      chk("t3_chan", m_chan, 64'(c));
      chk("t3_data", m_data, {pkt(18'(c + 100), 3'(c), 3'b111), pkt(18'(c + 1), 3'(c), 3'b111)});
      chk("t3_last", m_last, 0);
      step();
    end
    chk("t3_empty", m_valid, 0);
    pulse_clear();
    chk("t3_ovf_cleared", overflow, 0);

    // Restart after 10 strobes
    fs(8'h01, 3'b010);
    send(24'hABCDEF, 24'h123456, 10);
    fs(8'h01, 3'b010);
    chk("t4_frame_error", frame_error, 1);
    chk("t4_busy", busy, 1);
    send(24'h0AAAC2, 24'h055502, 24);
    chk("t4_no_partial", m_valid, 0);
    step();
    chk("t4_valid", m_valid, 1);
    chk("t4_data", m_data, {24'h055502, 24'h0AAAC2});
    chk("t4_chan", m_chan, 0);
    chk("t4_last", m_last, 1);
    chk("t4_id_error", id_error, 0);
    step();
    pulse_clear();
    chk("t4_fe_cleared", frame_error, 0);

    // Empty mask: frame_start ignored
    fs(8'h00, 3'b111);
    chk("t5_busy", busy, 0);
    send(24'hFFFFFF, 24'hFFFFFF, 24);
    step(); step();
    chk("t5_valid", m_valid, 0);
    chk("t5_busy_end", busy, 0);
    chk("t5_flags", {overflow, id_error, frame_error}, 0);

    // Async reset with two buffered words and a partial third
    m_ready = 1'b0;
    fs(8'h07, 3'b111);
    send(pkt(18'h1, 3'd0, 3'b111), pkt(18'h2, 3'd0, 3'b111), 24);
    send(pkt(18'h3, 3'd5, 3'b111), pkt(18'h4, 3'd1, 3'b111), 24);
    send(24'hFFFFFF, 24'hFFFFFF, 5);
    chk("t6_pre_valid", m_valid, 1);
    chk("t6_pre_id_error", id_error, 1);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_valid", m_valid, 0);
    chk("t6_rst_data", m_data, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_flags", {overflow, id_error, frame_error}, 0);
    step();
    reset = 1'b0;
    m_ready = 1'b1;
    fs(8'h02, 3'b001);
    send(pkt(18'h2BEEF, 3'd1, 3'b001), pkt(18'h15555, 3'd1, 3'b001), 24);
    step();
    chk("t6_after_valid", m_valid, 1);
    chk("t6_after_data", m_data, {pkt(18'h15555, 3'd1, 3'b001), pkt(18'h2BEEF, 3'd1, 3'b001)});
    chk("t6_after_chan", m_chan, 1);
    chk("t6_after_last", m_last, 1);
    chk("t6_after_flags", {overflow, id_error, frame_error}, 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
